video_fetch_ctl: RTL

// - DRAM-side consumer of video_mode's fetch controls (video_addr, video_bw, fetch_sel/bsl/stb).
// - Issues video DRAM requests at the video_bw cadence and queues returned 16-bit words in a FIFO.
// - Packs FIFO words into the 32-bit fetch_data word read by video_render.
// - Sits between the DRAM arbiter and video_render.

---
 rtl/video_fetch_ctl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/video_fetch_ctl.sv
// video_fetch_ctl: issues video DRAM requests at the video_bw cadence, queues
// the returned 16-bit words in a small FIFO and packs popped words into the
// 32-bit fetch_data word read by the renderer.
// Optional build macro VFETCH_STATS_EN adds words_last, the number of words
// pushed during the previous line.
module video_fetch_ctl #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        line_start,
   input  logic        video_go,
   input  logic [4:0]  video_bw,
   input  logic [20:0] video_addr,
   input  logic        dram_next,
   input  logic        video_strobe,
   input  logic [15:0] dram_rdata,
   input  logic        fetch_stb,
   input  logic [3:0]  fetch_sel,
   input  logic [1:0]  fetch_bsl,
   output logic        video_req,
   output logic [20:0] dram_addr,
   output logic        video_next,
   output logic [31:0] fetch_data,
   output logic        ovf,
`ifdef VFETCH_STATS_EN
   output logic [7:0]  words_last,
`endif
   output logic        unf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;          // holds 0..DEPTH
   localparam int DW = CW + 1;          // discard counter, may hold leftovers of two lines
   localparam logic [CW:0]   DEPTH_W  = (CW+1)'(DEPTH);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [DW-1:0] DISC_MAX = '1;

   logic [2:0]    slot_q, slot_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] out_q, out_d;
   logic [DW-1:0] disc_q, disc_d;
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic          vnext_q, vnext_d;
   logic [20:0]   addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic          ovf_q, ovf_d, unf_q, unf_d;
   logic [15:0]   mem [DEPTH];
   logic          mem_we;
   logic [DW:0]   pend;

   logic [2:0]    slot_last, need;
   logic [CW:0]   occ;
   logic          grant, take, pop_req, fifo_empty, fifo_full, push_ok, stored, popped;
   logic [15:0]   pop_word;
   logic [7:0]    lane_byte [4];

   // decode slots-per-window (as last slot index) and words needed per window
   always_comb begin : bw_decode
      case (video_bw[4:3])
         2'b00:   slot_last = 3'd1;
         2'b01:   slot_last = 3'd3;
         default: slot_last = 3'd7;
      endcase
      case (video_bw[2:0])
         3'b010:  need = 3'd2;
         3'b100:  need = 3'd4;
         default: need = 3'd1;
      endcase
   end

   assign occ        = (CW+1)'(count_q) + (CW+1)'(out_q);
   assign video_req  = video_go && (slot_q < need) && (occ < DEPTH_W);
   // line_start suppresses the grant so no request is counted for the old line
   assign grant      = dram_next && video_req && !line_start;
   assign take       = video_strobe && (disc_q == '0);
   assign pop_req    = fetch_stb && (fetch_sel != 4'b0000);
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == DEPTH_C);
   // a full FIFO still accepts a word when a pop frees a slot in the same clk
   assign push_ok    = take && (!fifo_full || pop_req);
   // an empty FIFO with a simultaneous pop forwards the word without storing it
   assign stored     = push_ok && !(fifo_empty && pop_req);
   assign popped     = pop_req && !fifo_empty;
   assign pop_word   = fifo_empty ? (take ? dram_rdata : 16'h0000) : mem[rd_q];

   // per-lane byte source: even lanes follow bsl[0], odd lanes bsl[1]
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_byte[gi] = fetch_bsl[gi % 2] ? pop_word[15:8] : pop_word[7:0];
   end

   // next-state for slot counter, request accounting, FIFO and packer
   always_comb begin : next_state
      slot_d  = slot_q;
      count_d = count_q;
      out_d   = out_q;
      disc_d  = disc_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      vnext_d = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      mem_we  = 1'b0;
      pend    = '0;
      if (line_start) begin
         slot_d  = 3'd0;
         count_d = '0;
         wr_d    = '0;
         rd_d    = '0;
         out_d   = '0;
         // every return still in flight belongs to the old line; a strobe in
         // this clk is one of them and is already dropped
         pend = (DW+1)'(disc_q) + (DW+1)'(out_q);
         if (video_strobe && (pend != '0))
            pend = pend - (DW+1)'(1);
         disc_d = (pend > (DW+1)'(DISC_MAX)) ? DISC_MAX : pend[DW-1:0];
      end else begin
         if (!video_go)
            slot_d = 3'd0;
         else if (dram_next)
            slot_d = (slot_q == slot_last) ? 3'd0 : slot_q + 3'd1;

         if (grant) begin
            vnext_d = 1'b1;
            addr_d  = video_addr;
         end

         if (video_strobe && !take)
            disc_d = disc_q - DW'(1);
         out_d = out_q + CW'(grant) - CW'(take && (out_q != '0));

         if (take && !push_ok)
            ovf_d = 1'b1;
         if (stored) begin
            mem_we = 1'b1;
            wr_d   = wr_q + AW'(1);
         end
         if (pop_req) begin
            for (int i = 0; i < 4; i++)
               if (fetch_sel[i])
                  data_d[8*i +: 8] = lane_byte[i];
            if (fifo_empty && !take)
               unf_d = 1'b1;
         end
         if (popped)
            rd_d = rd_q + AW'(1);
         count_d = count_q + CW'(stored) - CW'(popped);
      end
   end

   // FIFO storage, no reset so it maps onto RAM
   always_ff @(posedge clk) begin : fifo_mem
      if (mem_we)
         mem[wr_q] <= dram_rdata;
   end

   // state registers
   always_ff @(posedge clk) begin : state_reg
      if (!rst_n) begin
         slot_q  <= '0;
         count_q <= '0;
         out_q   <= '0;
         disc_q  <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         vnext_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         slot_q  <= slot_d;
         count_q <= count_d;
         out_q   <= out_d;
         disc_q  <= disc_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         vnext_q <= vnext_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign dram_addr  = addr_q;
   assign video_next = vnext_q;
   assign fetch_data = data_q;
   assign ovf        = ovf_q;
   assign unf        = unf_q;

`ifdef VFETCH_STATS_EN
   logic [7:0] wcnt_q, wcnt_d, wlast_q, wlast_d;

   // per-line pushed-word counter, latched and cleared at line_start
   always_comb begin : stats_next
      wcnt_d  = wcnt_q;
      wlast_d = wlast_q;
      if (line_start) begin
         wlast_d = wcnt_q;
         wcnt_d  = 8'd0;
      end else if (push_ok && (wcnt_q != 8'hFF)) begin
         wcnt_d = wcnt_q + 8'd1;
      end
   end

   // stats registers
   always_ff @(posedge clk) begin : stats_reg
      if (!rst_n) begin
         wcnt_q  <= 8'd0;
         wlast_q <= 8'd0;
      end else begin
         wcnt_q  <= wcnt_d;
         wlast_q <= wlast_d;
      end
   end

   assign words_last = wlast_q;
`endif

endmodule
